// File: rtl/tcb_lib_arbiter_rr.sv
// Round-robin arbiter for TCB managers: holds a grant until its handshake, then rotates priority.
// Optional burst lock (at most BRS consecutive transfers) compiled in with TCB_LIB_ARBITER_RR_LOCK_EN.
module tcb_lib_arbiter_rr #(
  parameter int unsigned SPN = 3,
  parameter int unsigned SPL = $clog2(SPN),
  parameter int unsigned BRS = 4
)(
  input  logic           clk,
  input  logic           rst,
  input  logic [SPN-1:0] vld,
  input  logic [SPN-1:0] lck,
  input  logic           rdy,
  output logic [SPL-1:0] sel,
  output logic [SPN-1:0] gnt,
  output logic           trn,
  output logic           dbg_sta,
  output logic [SPL-1:0] dbg_ptr
);

  // Handshake: a transfer completes in any cycle where the granted manager has
  // vld=1 and the subordinate has rdy=1; that cycle is the last cycle of the grant.

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} sta_t;

  localparam logic [SPL-1:0] LAST = SPL'(SPN - 1);

  sta_t           sta, sta_nxt;
  logic [SPL-1:0] ptr, ptr_nxt;
  logic [SPL-1:0] hld, hld_nxt;
  logic [SPL-1:0] cand, ptr_inc;
  logic           cand_ok;
  int             k;

  // Scan from the highest offset down so the lowest offset from ptr wins.
  always_comb begin
    cand    = ptr;
    cand_ok = 1'b0;
    k       = 0;
    for (int j = int'(SPN) - 1; j >= 0; j--) begin
      k = int'(ptr) + j;
      if (k >= int'(SPN)) k = k - int'(SPN);
      if (vld[SPL'(k)]) begin
        cand    = SPL'(k);
        cand_ok = 1'b1;
      end
    end
  end

  always_comb begin
    sel     = ptr;
    gnt     = '0;
    sta_nxt = sta;
    hld_nxt = hld;
    if (!rst) begin
      sel = '0;
    end else begin
      case (sta)
        IDLE: begin
          if (cand_ok) begin
            sel       = cand;
            gnt[cand] = 1'b1;
            if (!rdy) begin
              sta_nxt = BUSY;
              hld_nxt = cand;
            end
          end
        end
        BUSY: begin
          sel = hld;
          if (vld[hld]) begin
            gnt[hld] = 1'b1;
            if (rdy) sta_nxt = IDLE;
          end else begin
            // Manager withdrew its request mid-grant: release without a transfer.
            sta_nxt = IDLE;
          end
        end
        default: sta_nxt = IDLE;
      endcase
    end
    trn = |(gnt & vld) & rdy;
  end

  assign ptr_inc = (sel == LAST) ? '0 : sel + SPL'(1);

`ifdef TCB_LIB_ARBITER_RR_LOCK_EN
  logic [7:0] cnt, cnt_nxt;

  always_comb begin
    ptr_nxt = ptr;
    cnt_nxt = cnt;
    if (trn) begin
      if (lck[sel] && (({1'b0, cnt} + 9'd1) < 9'(BRS))) begin
        cnt_nxt = cnt + 8'd1;
      end else begin
        ptr_nxt = ptr_inc;
        cnt_nxt = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt <= '0;
    else      cnt <= cnt_nxt;
  end
`else
  logic unused_lck;
  assign unused_lck = ^lck;
  localparam int unsigned unused_brs = BRS;

  always_comb begin
    ptr_nxt = ptr;
    if (trn) ptr_nxt = ptr_inc;
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sta <= IDLE;
      ptr <= '0;
      hld <= '0;
    end else begin
      sta <= sta_nxt;
      ptr <= ptr_nxt;
      hld <= hld_nxt;
    end
  end

  assign dbg_sta = (sta == BUSY);
  assign dbg_ptr = ptr;

endmodule

// File: doc/tcb_lib_arbiter_rr.md
# tcb_lib_arbiter_rr

Round-robin request arbiter for the TCB manager-side interconnect. It sits directly upstream of `tcb_lib_multiplexer` and drives its `sel` input. It observes `vld` from SPN TCB managers and `rdy` from the shared subordinate. It holds each grant stable until the granted request completes its handshake, then rotates priority so no manager starves. It is the fairness-based alternative to the fixed-priority arbiter.

## Interface
- `SPN`, default 3: number of manager ports; any value ≥2, including non-powers of 2.
- `SPL`, default `$clog2(SPN)`: select width.
- `BRS`, default 4: maximum consecutive locked transfers per grant. Used only with the lock feature compiled in; legal range 1..255.

Ports:
- `clk`, input, 1: clock; all state updates on the rising edge.
- `rst`, input, 1: asynchronous active-low reset.
- `vld`, input, SPN: per-manager request valid (`tcb_man[i].vld`).
- `lck`, input, SPN: per-manager lock request. Used only with the lock feature; otherwise ignored.
- `rdy`, input, 1: subordinate ready (`tcb_sub.rdy`).
- `sel`, output, SPL: selected manager index, connected to multiplexer `sel`.
- `gnt`, output, SPN: one-hot grant; all zero when no request is selected.
- `trn`, output, 1: transfer strobe, equal to `|(gnt & vld) & rdy`.

## Operation
Registers:
- `ptr` (SPL bits): round-robin start index.
- `sta`: state, IDLE or BUSY.
- `hld` (SPL bits): held index.
- `cnt` (8 bits): lock counter, present only with the lock feature.

IDLE state:
- The candidate is the first index `i` with `vld[i]=1`, searched `ptr, ptr+1, …, SPN-1, 0, …, ptr-1`.
- If a candidate exists: `sel` = candidate, `gnt` = one-hot(candidate).
  - If `rdy=1`: transfer completes and the state stays IDLE.
  - If `rdy=0`: `hld` ← candidate and the state goes to BUSY.
- If no candidate exists: `sel=ptr`, `gnt=0`, and all state is unchanged.

BUSY state:
- `sel=hld` and `gnt` = one-hot(`hld`), regardless of any other `vld` change.
- On `trn`, the state returns to IDLE.
- If `vld[hld]` drops without `trn` (a protocol violation), the state returns to IDLE, `gnt` is zeroed in the same cycle, and `ptr` is unchanged.

Pointer update on every `trn`:
- `ptr` ← `sel+1`, wrapping to 0 when `sel+1 == SPN` (compare against SPN, not 2^SPL).

Other rules:
- `sel` never takes a value ≥ SPN.
- `gnt` has at most one bit set.

## Timing
- Zero-cycle request→grant latency in IDLE: `sel`/`gnt` are combinational from `vld` and `ptr`.
- A grant is stable from its first cycle until the `trn` cycle inclusive.
- `ptr` and `sta` change on the clock edge that ends the `trn` cycle. The next grant is therefore available in the following cycle, so back-to-back transfers run at one per cycle.
- The multiplexer delays `sel` by DLY for the response path. This block adds no response tracking.
- Reset values, forced asynchronously while `rst=0`: `ptr=0`, `sta=IDLE`, `hld=0`, `cnt=0`.
  - Outputs during reset: `gnt=0`, `sel=0`, `trn=0`. Requests are ignored while `rst=0`.
- Reset asserted mid-BUSY drops the held grant immediately, without waiting for a clock edge.
- After release, arbitration restarts from port 0.
- Simultaneous `vld` on all ports while `ptr=k`: port k wins.

## Configuration
Macro `TCB_LIB_ARBITER_RR_LOCK_EN`.

Defined:
- On `trn` with `lck[sel]=1` and `cnt+1 < BRS`: `ptr` is not advanced and `cnt` increments, so the same manager stays first in the search.
- Otherwise `ptr` advances and `cnt` ← 0.
- A port can therefore hold the bus for at most BRS consecutive transfers.

Undefined:
- `lck` is unused, `cnt` is not implemented, and `ptr` advances on every `trn`.

## Test plan
- SPN=3, `vld=3'b111`, `rdy=1` constantly, reset released → `sel` sequence 0,1,2,0,1 on consecutive cycles, with `trn=1` every cycle.
- SPN=3, `vld=3'b100`, `rdy=0` for 3 cycles:
  - Stimulus: `vld[0]` rises in the second cycle, then `rdy=1`.
  - Required: `sel=2` for all 4 cycles, then `sel=0` the next cycle.
  - Required: `ptr` goes 0→0 (unchanged while stalled) → 0 after port 2 completes (wrap 2+1=3→0).
- SPN=5, `vld=5'b10000` only, `rdy=1` → `sel=4`, then `ptr` wraps to 0. Never `sel≥5`.
- `vld=0` with `ptr=2` → `gnt=0`, `sel=2`, `trn=0`, `ptr` stays 2.
- In BUSY with `hld=1`, drive `rst=0` between clock edges → `gnt=0` and `sel=0` before the next edge. After release with `vld=3'b010`, `rdy=1` → `sel=1`, `trn=1`, then `ptr=2`.
- With `TCB_LIB_ARBITER_RR_LOCK_EN`, BRS=4, SPN=3: `vld=3'b111`, `lck=3'b010`, `rdy=1`, start `ptr=1` → `sel` sequence 1,1,1,1,2,0,1. Without the macro, the same stimulus → 1,2,0,1.
